// File: rtl/img_msg_master.sv
// Sequences frames into the image solver's slave-register port and collects its results.
// Results go into a small first-word-fall-through buffer that drains on m_valid/m_ready.
module img_msg_master #(
   parameter int          RST_CYC    = 4,
   parameter int          HOLD_CYC   = 3,
   parameter logic [31:0] TIMEOUT    = 32'd65535,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] frame_len,
   input  logic [31:0] s_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic [31:0] m_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [31:0] slv_reg0,
   output logic [31:0] slv_reg1,
   input  logic [31:0] slv_reg2,
   input  logic [31:0] slv_reg3,
   output logic        busy,
   output logic        done,
   output logic        timeout,
   output logic        ovf,
   output logic [15:0] words_out
);

   localparam int          AW        = $clog2(FIFO_DEPTH);
   localparam logic [7:0]  RST_LAST  = 8'(RST_CYC - 1);
   localparam logic [7:0]  HOLD_LAST = 8'(HOLD_CYC);
   localparam logic [31:0] TO_LAST   = TIMEOUT - 32'd1;

   typedef enum logic [2:0] {
      S_IDLE, S_RST, S_LOAD, S_SEND, S_WAIT, S_DONE
   } state_t;

   state_t      state, state_nxt;
   logic [7:0]  cnt;
   logic [15:0] remaining;
   logic [31:0] idle_cnt;
   logic        im_work, im_start;
   logic        om_start_q, om_work_q, seen_work;
   logic        cap_en, cap, work_edge, res_done, to_hit;
   logic        rst_last, hold_last;

   logic [31:0] mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic        full, empty, pop, push_ok;
   logic        unused_bits;

   assign unused_bits = ^slv_reg3[31:2];

   assign cap_en    = (state == S_LOAD) || (state == S_SEND) || (state == S_WAIT);
   assign cap       = cap_en && (slv_reg3[1] != om_start_q);
   assign work_edge = slv_reg3[0] != om_work_q;
   assign res_done  = seen_work && !slv_reg3[0];
   assign to_hit    = (idle_cnt == TO_LAST) && !cap && !work_edge;
   assign rst_last  = cnt == RST_LAST;
   assign hold_last = cnt == HOLD_LAST;

   assign empty   = wr_ptr == rd_ptr;
   assign full    = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
   assign pop     = m_valid && m_ready;
   assign push_ok = cap && (!full || pop);
   assign m_valid = !empty;
   assign m_data  = mem[rd_ptr[AW-1:0]];

   assign s_ready  = state == S_LOAD;
   assign busy     = state != S_IDLE;
   assign done     = state == S_DONE;
   // Solver reset is a pure state decode so an async rst releases it immediately.
   assign slv_reg0 = {27'd0, (state != S_RST), 2'b00, im_start, im_work};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (start) state_nxt = S_RST;
         S_RST:  if (rst_last) state_nxt = (remaining == 16'd0) ? S_WAIT : S_LOAD;
         S_LOAD: if (s_valid) state_nxt = S_SEND;
         S_SEND: if (hold_last) state_nxt = (remaining == 16'd1) ? S_WAIT : S_LOAD;
         S_WAIT: if (res_done || to_hit) state_nxt = S_DONE;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= 8'd0;
         remaining <= 16'd0;
         idle_cnt  <= 32'd0;
         im_work   <= 1'b0;
         im_start  <= 1'b0;
         slv_reg1  <= 32'd0;
      end else begin
         cnt <= (state_nxt != state) ? 8'd0 : (cnt == 8'hff) ? cnt : cnt + 8'd1;
         idle_cnt <= (state != S_WAIT || cap || work_edge) ? 32'd0 : idle_cnt + 32'd1;
         if (state == S_IDLE && start)
            remaining <= frame_len;
         else if (state == S_SEND && hold_last)
            remaining <= remaining - 16'd1;
         if ((state == S_IDLE && start) || state == S_RST)
            im_start <= 1'b0;
         else if (state == S_SEND && cnt == 8'd0)
            im_start <= ~im_start;
         if (state == S_RST && rst_last)
            im_work <= remaining != 16'd0;
         else if (state == S_SEND && hold_last && remaining == 16'd1)
            im_work <= 1'b0;
         if (state == S_LOAD && s_valid)
            slv_reg1 <= s_data;
      end
   end

   // Result-side tracking; om_start_q follows the solver every cycle so
   // toggles outside a frame never turn into captures later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         om_start_q <= 1'b0;
         om_work_q  <= 1'b0;
         seen_work  <= 1'b0;
         timeout    <= 1'b0;
         ovf        <= 1'b0;
         words_out  <= 16'd0;
      end else begin
         om_start_q <= slv_reg3[1];
         om_work_q  <= slv_reg3[0];
         if (state == S_IDLE && start) begin
            seen_work <= 1'b0;
            timeout   <= 1'b0;
            ovf       <= 1'b0;
            words_out <= 16'd0;
         end else begin
            if (cap_en && slv_reg3[0]) seen_work <= 1'b1;
            if (state == S_WAIT && !res_done && to_hit) timeout <= 1'b1;
            if (cap && full && !pop) ovf <= 1'b1;
            if (cap && words_out != 16'hffff) words_out <= words_out + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= slv_reg2;
   end

endmodule

// File: doc/img_msg_master.md
Name: img_msg_master

Overview:
- Fabric-side counterpart of the image solver's slave-register message port.
- Drives slv_reg0/slv_reg1 (reset, im_work, im_start toggle, im_data) from a valid/ready word stream, then collects result words (om_data on slv_reg2, om_work/om_start on slv_reg3) into an output stream.
- Replaces PS software sequencing so that frames can be pushed to the solver from hardware.

Parameters:
- RST_CYC, 4, cycles solver rst_n (slv_reg0[4]) is held low at frame start; legal range 1..255.
- HOLD_CYC, 3, cycles each im_data word is held after its im_start toggle before the next word may be sent; legal range 1..255.
- TIMEOUT, 65535, maximum idle cycles in WAIT_RES before the frame is aborted (32-bit counter).
- FIFO_DEPTH, 4, result buffer depth; power of 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a frame; ignored unless in IDLE.
- frame_len  in  16  number of input words; sampled on start; 0 means skip SEND.
- s_data  in  32  input word.
- s_valid  in  1  s_data valid.
- s_ready  out  1  word accepted when s_valid && s_ready.
- m_data  out  32  result word.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accept.
- slv_reg0  out  32  bit0 im_work, bit1 im_start, bit4 solver rst_n; all other bits 0.
- slv_reg1  out  32  im_data.
- slv_reg2  in  32  om_data.
- slv_reg3  in  32  bit0 om_work, bit1 om_start; all other bits ignored.
- busy  out  1  high whenever not in IDLE.
- done  out  1  one-cycle pulse on return to IDLE.
- timeout  out  1  sticky; set on abort; cleared by start.
- ovf  out  1  sticky; set when a result is lost; cleared by start.
- words_out  out  16  results captured in the current frame (saturating).

Behaviour:
- Reset values: slv_reg0 = 0x10 (rst_n=1, im_work=0, im_start=0); slv_reg1=0; s_ready, m_valid, busy, done, timeout, ovf = 0; words_out=0; FIFO empty; FSM=IDLE.
- IDLE:
  - On start: latch frame_len, clear timeout, ovf and words_out, go to RST.
- RST:
  - rst_n=0 for RST_CYC cycles; im_start forced 0.
  - Then rst_n=1, im_work=1, go to LOAD; go to WAIT_RES instead if frame_len==0.
- LOAD:
  - s_ready=1 only in this state.
  - On handshake: slv_reg1<=s_data, go to SEND.
- SEND:
  - First cycle: im_start toggles (im_data is already stable one cycle earlier).
  - Hold HOLD_CYC cycles. Then decrement the remaining count; if nonzero go to LOAD, else drop im_work and go to WAIT_RES.
  - Minimum input rate is one word per (HOLD_CYC+2) cycles.
- Result capture:
  - Active in LOAD, SEND and WAIT_RES.
  - om_start_q registers slv_reg3[1]. Any change (slv_reg3[1] != om_start_q) pushes slv_reg2 into the FIFO and increments words_out.
  - Full FIFO with no simultaneous pop: word dropped, ovf=1.
  - Simultaneous push and pop on a full FIFO succeeds.
- WAIT_RES:
  - Exit to DONE when om_work has been seen high at least once in this frame and is now low, after any capture in that same cycle.
  - Idle counter resets on any capture or om_work edge. At TIMEOUT: timeout=1, go to DONE.
- DONE:
  - Pulse done, go to IDLE.
  - FIFO keeps draining after DONE; no capture in IDLE.
- m_valid = FIFO not empty; m_data = FIFO head; FWFT, zero-latency pop on m_valid && m_ready.
- start while busy is ignored.
- rst mid-frame: everything returns to reset values immediately, FIFO contents discarded, solver rst_n returns to 1.

Test Plan:
- Frame: frame_len=3, words 0xA1,0xB2,0xC3, RST_CYC=4, HOLD_CYC=3 -> rst_n low exactly 4 cycles; slv_reg1 shows A1,B2,C3 with im_start toggling 3 times (final value 1); consecutive toggles at least 5 cycles apart; im_work falls after the third hold.
- Result collection: solver model raises om_work and toggles om_start with 0x11,0x22; m_ready=1 -> m_data 0x11 then 0x22; words_out=2; done pulses one cycle after om_work falls.
- Backpressure: m_ready=0 while 6 results arrive, FIFO_DEPTH=4 -> 4 buffered, ovf=1, words_out=6; after m_ready=1, exactly 4 words drain in order.
- Timeout: TIMEOUT=100, solver never raises om_work -> timeout=1 and done pulses 100 cycles after entering WAIT_RES; next start clears timeout.
- Edge cases: frame_len=0 -> no im_start toggle, goes straight to WAIT_RES; start pulsed during SEND -> ignored.
- Reset mid-SEND: rst asserted -> slv_reg0=0x10, busy=0, m_valid=0 in the same cycle.
